// File: rtl/mpu6050_i2c_responder.sv
// I2C target emulating the MPU6050 register subset used by the gyro driver (config regs, WHO_AM_I, gyro Z).
// Optional SCL/SDA stability filter enabled by defining I2C_RESP_GLITCH_FILTER_EN.
module mpu6050_i2c_responder #(
    parameter logic [6:0]  DEVICE_ADDR  = 7'h68,
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h68,
    parameter int unsigned FILTER_LEN   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] gyro_z,
    output logic [7:0]  pwr_mgmt_1,
    output logic [7:0]  smplrt_div,
    output logic [7:0]  int_enable,
    output logic        wr_strobe,
    output logic        busy
);

`ifdef I2C_RESP_GLITCH_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_MACK      = 4'd8,
        ST_WAIT      = 4'd9
    } state_t;

    logic scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r;
    logic scl_f_s, sda_f_s, scl_prev_r, sda_prev_r;
    logic scl_rise_s, scl_fall_s, start_s, stop_s;

    state_t      state_r, state_nxt_s;
    logic [3:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s;
    logic [7:0]  tx_r, tx_nxt_s;
    logic [7:0]  ptr_r, ptr_nxt_s;
    logic        rw_r, rw_nxt_s;
    logic        phase_r, phase_nxt_s;
    logic        sda_oe_r, sda_oe_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        wr_strobe_r, wr_strobe_nxt_s;
    logic [7:0]  pwr_r, pwr_nxt_s;
    logic [7:0]  smp_r, smp_nxt_s;
    logic [7:0]  ien_r, ien_nxt_s;
    logic [15:0] snap_r, snap_nxt_s;
    logic [7:0]  rd_byte_s, rx_byte_s;

    function automatic logic [7:0] read_reg(
        input logic [7:0]  addr,
        input logic [15:0] snap,
        input logic [7:0]  pwr,
        input logic [7:0]  smp,
        input logic [7:0]  ien
    );
        case (addr)
            8'h47:   read_reg = snap[15:8];
            8'h48:   read_reg = snap[7:0];
            8'h75:   read_reg = WHO_AM_I_VAL;
            8'h6B:   read_reg = pwr;
            8'h19:   read_reg = smp;
            8'h38:   read_reg = ien;
            default: read_reg = 8'h00;
        endcase
    endfunction

    // Two-flop synchronizers and previous-level registers for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_in;
            scl_sync_r <= scl_meta_r;
            sda_meta_r <= sda_in;
            sda_sync_r <= sda_meta_r;
            scl_prev_r <= scl_f_s;
            sda_prev_r <= sda_f_s;
        end
    end

    generate
        if (FILTER_ON && (FILTER_LEN != 0)) begin : g_filter
            localparam int unsigned CW = $clog2(FILTER_LEN + 1);
            logic [1:0] raw_s;
            logic [1:0] filt_s;
            assign raw_s = {scl_sync_r, sda_sync_r};
            for (genvar i = 0; i < 2; i++) begin : g_line
                logic          filt_r;
                logic [CW-1:0] cnt_r;
                // A new level is accepted only after FILTER_LEN consecutive differing samples.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        filt_r <= 1'b1;
                        cnt_r  <= '0;
                    end else if (raw_s[i] == filt_r) begin
                        cnt_r <= '0;
                    end else if (cnt_r == CW'(FILTER_LEN - 1)) begin
                        filt_r <= raw_s[i];
                        cnt_r  <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                assign filt_s[i] = filt_r;
            end
            assign scl_f_s = filt_s[1];
            assign sda_f_s = filt_s[0];
        end else begin : g_bypass
            assign scl_f_s = scl_sync_r;
            assign sda_f_s = sda_sync_r;
        end
    endgenerate

    // START/STOP need SCL high on both samples, so an SCL edge in the same cycle suppresses them.
    assign scl_rise_s = scl_f_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_f_s & scl_prev_r;
    assign start_s    = scl_f_s & scl_prev_r & sda_prev_r & ~sda_f_s;
    assign stop_s     = scl_f_s & scl_prev_r & ~sda_prev_r & sda_f_s;
    assign rd_byte_s  = read_reg(ptr_r, snap_r, pwr_r, smp_r, ien_r);
    assign rx_byte_s  = {shift_r[6:0], sda_f_s};

    // Next-state and datapath decode for the byte/ACK protocol engine.
    always_comb begin
        state_nxt_s     = state_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shift_nxt_s     = shift_r;
        tx_nxt_s        = tx_r;
        ptr_nxt_s       = ptr_r;
        rw_nxt_s        = rw_r;
        phase_nxt_s     = phase_r;
        sda_oe_nxt_s    = sda_oe_r;
        busy_nxt_s      = busy_r;
        wr_strobe_nxt_s = 1'b0;
        pwr_nxt_s       = pwr_r;
        smp_nxt_s       = smp_r;
        ien_nxt_s       = ien_r;
        snap_nxt_s      = snap_r;

        if (stop_s) begin
            state_nxt_s  = ST_IDLE;
            busy_nxt_s   = 1'b0;
            sda_oe_nxt_s = 1'b0;
        end else if (start_s) begin
            state_nxt_s   = ST_ADDR;
            bit_cnt_nxt_s = 4'd0;
            phase_nxt_s   = 1'b0;
            sda_oe_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (scl_rise_s) begin
                        shift_nxt_s   = rx_byte_s;
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                        if (bit_cnt_r == 4'd7) begin
                            bit_cnt_nxt_s = 4'd0;
                            phase_nxt_s   = 1'b0;
                            if (state_r == ST_ADDR) begin
                                if (shift_r[6:0] == DEVICE_ADDR) begin
                                    state_nxt_s = ST_ADDR_ACK;
                                    busy_nxt_s  = 1'b1;
                                    rw_nxt_s    = sda_f_s;
                                    snap_nxt_s  = sda_f_s ? gyro_z : snap_r;
                                end else begin
                                    state_nxt_s = ST_WAIT;
                                end
                            end else if (state_r == ST_REG) begin
                                state_nxt_s = ST_REG_ACK;
                                ptr_nxt_s   = rx_byte_s;
                            end else begin
                                state_nxt_s = ST_WDATA_ACK;
                                ptr_nxt_s   = ptr_r + 8'd1;
                                case (ptr_r)
                                    8'h6B: begin
                                        pwr_nxt_s       = rx_byte_s;
                                        wr_strobe_nxt_s = 1'b1;
                                    end
                                    8'h19: begin
                                        smp_nxt_s       = rx_byte_s;
                                        wr_strobe_nxt_s = 1'b1;
                                    end
                                    8'h38: begin
                                        ien_nxt_s       = rx_byte_s;
                                        wr_strobe_nxt_s = 1'b1;
                                    end
                                    default: wr_strobe_nxt_s = 1'b0;
                                endcase
                            end
                        end else begin
                            phase_nxt_s = phase_r;
                        end
                    end else begin
                        shift_nxt_s = shift_r;
                    end
                end
                ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
                    // phase 0: first SCL fall starts the ACK slot; phase 1: next fall ends it.
                    if (scl_fall_s) begin
                        if (!phase_r) begin
                            sda_oe_nxt_s = 1'b1;
                            phase_nxt_s  = 1'b1;
                        end else if ((state_r == ST_ADDR_ACK) && rw_r) begin
                            state_nxt_s   = ST_RDATA;
                            phase_nxt_s   = 1'b0;
                            bit_cnt_nxt_s = 4'd0;
                            sda_oe_nxt_s  = ~rd_byte_s[7];
                            tx_nxt_s      = {rd_byte_s[6:0], 1'b0};
                            ptr_nxt_s     = ptr_r + 8'd1;
                        end else begin
                            state_nxt_s  = (state_r == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
                            phase_nxt_s  = 1'b0;
                            sda_oe_nxt_s = 1'b0;
                        end
                    end else begin
                        phase_nxt_s = phase_r;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    end else if (scl_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            state_nxt_s   = ST_MACK;
                            phase_nxt_s   = 1'b0;
                            bit_cnt_nxt_s = 4'd0;
                            sda_oe_nxt_s  = 1'b0;
                        end else begin
                            sda_oe_nxt_s = ~tx_r[7];
                            tx_nxt_s     = {tx_r[6:0], 1'b0};
                        end
                    end else begin
                        tx_nxt_s = tx_r;
                    end
                end
                ST_MACK: begin
                    if (scl_rise_s) begin
                        if (!sda_f_s) begin
                            phase_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_WAIT;
                        end
                    end else if (scl_fall_s && phase_r) begin
                        state_nxt_s   = ST_RDATA;
                        phase_nxt_s   = 1'b0;
                        bit_cnt_nxt_s = 4'd0;
                        sda_oe_nxt_s  = ~rd_byte_s[7];
                        tx_nxt_s      = {rd_byte_s[6:0], 1'b0};
                        ptr_nxt_s     = ptr_r + 8'd1;
                    end else begin
                        phase_nxt_s = phase_r;
                    end
                end
                ST_IDLE, ST_WAIT: begin
                    state_nxt_s = state_r;
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    sda_oe_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // Protocol state, pointer, config registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'h00;
            tx_r        <= 8'h00;
            ptr_r       <= 8'h00;
            rw_r        <= 1'b0;
            phase_r     <= 1'b0;
            sda_oe_r    <= 1'b0;
            busy_r      <= 1'b0;
            wr_strobe_r <= 1'b0;
            pwr_r       <= 8'h40;
            smp_r       <= 8'h00;
            ien_r       <= 8'h00;
            snap_r      <= 16'h0000;
        end else begin
            state_r     <= state_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            tx_r        <= tx_nxt_s;
            ptr_r       <= ptr_nxt_s;
            rw_r        <= rw_nxt_s;
            phase_r     <= phase_nxt_s;
            sda_oe_r    <= sda_oe_nxt_s;
            busy_r      <= busy_nxt_s;
            wr_strobe_r <= wr_strobe_nxt_s;
            pwr_r       <= pwr_nxt_s;
            smp_r       <= smp_nxt_s;
            ien_r       <= ien_nxt_s;
            snap_r      <= snap_nxt_s;
        end
    end

    assign sda_oe     = sda_oe_r;
    assign busy       = busy_r;
    assign wr_strobe  = wr_strobe_r;
    assign pwr_mgmt_1 = pwr_r;
    assign smplrt_div = smp_r;
    assign int_enable = ien_r;

endmodule

// File: tb/tb_mpu6050_i2c_responder.sv
// Bench for mpu6050_i2c_responder: bit-banged I2C master, write-vector table and an ACK/data scoreboard.
module tb_mpu6050_i2c_responder;
    localparam int Q = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [15:0] gyro_z = 16'h0000;
    logic        sda_oe, wr_strobe, busy;
    logic [7:0]  pwr_mgmt_1, smplrt_div, int_enable;
    wire         sda_bus = sda_m & ~sda_oe;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;

    mpu6050_i2c_responder dut (
        .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
        .gyro_z(gyro_z), .pwr_mgmt_1(pwr_mgmt_1), .smplrt_div(smplrt_div),
        .int_enable(int_enable), .wr_strobe(wr_strobe), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    typedef struct {
        logic [7:0] dev;
        logic [7:0] ra;
        logic [7:0] wd;
        logic       ack;
        logic [7:0] e_pwr;
        logic [7:0] e_smp;
        logic [7:0] e_ien;
        int         e_stb;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] val;
    } sb_t;

    sb_t sb_q[$];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [7:0] val);
        sb_t e;
        e.name = name;
        e.val  = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [7:0] got);
        sb_t e;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: got 0x%0h expected a queued entry", got);
        end else begin
            e = sb_q.pop_front();
            check(e.name, {8'h00, got}, {8'h00, e.val});
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_bus;  tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic get_byte(input logic mack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(~mack);
    endtask

    vec_t       vec[6];
    logic       ack;
    logic [7:0] rd;
    logic [7:0] dev_w;
    int         stb_base;

    initial begin
        vec[0] = '{8'hD0, 8'h6B, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1};
        vec[1] = '{8'hD0, 8'h19, 8'h07, 1'b1, 8'h00, 8'h07, 8'h00, 1};
        vec[2] = '{8'hD0, 8'h38, 8'h01, 1'b1, 8'h00, 8'h07, 8'h01, 1};
        vec[3] = '{8'hD2, 8'h6B, 8'h55, 1'b0, 8'h00, 8'h07, 8'h01, 0};
        vec[4] = '{8'hD0, 8'h75, 8'hAA, 1'b1, 8'h00, 8'h07, 8'h01, 0};
        vec[5] = '{8'hD0, 8'h6B, 8'h03, 1'b1, 8'h03, 8'h07, 8'h01, 1};

        tick(5);
        reset = 1'b1;
        tick(4);
        check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_wr_strobe", {15'd0, wr_strobe}, 16'd0);
        check("rst_pwr", {8'h00, pwr_mgmt_1}, 16'h0040);
        check("rst_smplrt", {8'h00, smplrt_div}, 16'h0000);
        check("rst_int_en", {8'h00, int_enable}, 16'h0000);

        // Write-vector table: acks through the scoreboard, then register state and strobe count.
        for (int i = 0; i < 6; i++) begin
            stb_base = strobe_cnt;
            i2c_start;
            sb_push($sformatf("v%0d_ack_dev", i), {7'd0, vec[i].ack});
            put_byte(vec[i].dev, ack); sb_check({7'd0, ack});
            sb_push($sformatf("v%0d_ack_reg", i), {7'd0, vec[i].ack});
            put_byte(vec[i].ra, ack); sb_check({7'd0, ack});
            sb_push($sformatf("v%0d_ack_dat", i), {7'd0, vec[i].ack});
            put_byte(vec[i].wd, ack); sb_check({7'd0, ack});
            i2c_stop;
            tick(4);
            check($sformatf("v%0d_pwr", i), {8'h00, pwr_mgmt_1}, {8'h00, vec[i].e_pwr});
            check($sformatf("v%0d_smplrt", i), {8'h00, smplrt_div}, {8'h00, vec[i].e_smp});
            check($sformatf("v%0d_int_en", i), {8'h00, int_enable}, {8'h00, vec[i].e_ien});
            check($sformatf("v%0d_strobes", i), 16'(strobe_cnt - stb_base), 16'(vec[i].e_stb));
            check($sformatf("v%0d_busy", i), {15'd0, busy}, 16'd0);
        end

        // Burst write across the pointer wrap: all ACKed, nothing mapped written.
        stb_base = strobe_cnt;
        i2c_start;
        sb_push("wrap_ack_dev", 8'h01); put_byte(8'hD0, ack); sb_check({7'd0, ack});
        sb_push("wrap_ack_reg", 8'h01); put_byte(8'hFF, ack); sb_check({7'd0, ack});
        sb_push("wrap_ack_d0", 8'h01);  put_byte(8'h11, ack); sb_check({7'd0, ack});
        sb_push("wrap_ack_d1", 8'h01);  put_byte(8'h22, ack); sb_check({7'd0, ack});
        i2c_stop;
        tick(4);
        check("wrap_strobes", 16'(strobe_cnt - stb_base), 16'd0);
        check("wrap_pwr", {8'h00, pwr_mgmt_1}, 16'h0003);
        check("wrap_smplrt", {8'h00, smplrt_div}, 16'h0007);

        // WHO_AM_I through a repeated START, single byte with master NACK.
        i2c_start;
        sb_push("who_ack_dev", 8'h01); put_byte(8'hD0, ack); sb_check({7'd0, ack});
        sb_push("who_ack_reg", 8'h01); put_byte(8'h75, ack); sb_check({7'd0, ack});
        i2c_start;
        sb_push("who_ack_rd", 8'h01);  put_byte(8'hD1, ack); sb_check({7'd0, ack});
        check("who_busy", {15'd0, busy}, 16'd1);
        sb_push("who_data", 8'h68); get_byte(1'b0, rd); sb_check(rd);
        check("who_sda_released", {15'd0, sda_oe}, 16'd0);
        i2c_stop;
        tick(4);
        check("who_busy_after_stop", {15'd0, busy}, 16'd0);

        // Config read-back burst with auto-increment into an unmapped address.
        i2c_start;
        put_byte(8'hD0, ack);
        put_byte(8'h19, ack);
        i2c_start;
        put_byte(8'hD1, ack);
        sb_push("rb_smplrt", 8'h07); get_byte(1'b1, rd); sb_check(rd);
        sb_push("rb_unmapped", 8'h00); get_byte(1'b0, rd); sb_check(rd);
        i2c_stop;

        // Gyro snapshot coherency: sample changes between the high and low bytes.
        gyro_z = 16'hABCD;
        i2c_start;
        put_byte(8'hD0, ack);
        put_byte(8'h47, ack);
        i2c_start;
        sb_push("gyro_ack_rd", 8'h01); put_byte(8'hD1, ack); sb_check({7'd0, ack});
        sb_push("gyro_hi", 8'hAB); get_byte(1'b1, rd); sb_check(rd);
        gyro_z = 16'h1234;
        sb_push("gyro_lo", 8'hCD); get_byte(1'b0, rd); sb_check(rd);
        i2c_stop;
        tick(4);

        // Reset asserted while the address ACK is being driven.
        dev_w = 8'hD0;
        i2c_start;
        for (int i = 7; i >= 0; i--) put_bit(dev_w[i]);
        sda_m = 1'b1;
        tick(Q);
        check("mid_ack_driven", {15'd0, sda_oe}, 16'd1);
        check("mid_busy", {15'd0, busy}, 16'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_sda_oe", {15'd0, sda_oe}, 16'd0);
        tick(1);
        check("mid_rst_pwr", {8'h00, pwr_mgmt_1}, 16'h0040);
        check("mid_rst_busy", {15'd0, busy}, 16'd0);
        check("mid_rst_smplrt", {8'h00, smplrt_div}, 16'h0000);
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(8);
        check("post_rst_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("sb_drained", 16'(sb_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
